// File: rtl/dcache_ctrl.sv
// Data-cache controller in front of a 128x64b direct-mapped array: load lookup, load-miss MSHR,
// tagged memory bus and write-through stores. Statistics counters exist only with DCACHE_STATS_EN.
module dcache_ctrl #(
    parameter int MSHR_DEPTH = 4,
    parameter int MEM_TAG_W  = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    // Handshakes: the LSQ holds ld_en/ld_addr until ld_hit, and st_en/st_addr/st_data until
    // st_accept; ld_stall and a low st_accept mean "not taken this cycle, present again".
    input  logic                    ld_en,
    input  logic [31:0]             ld_addr,
    output logic                    ld_hit,
    output logic [63:0]             ld_data,
    output logic                    ld_stall,
    input  logic                    st_en,
    input  logic [31:0]             st_addr,
    input  logic [63:0]             st_data,
    output logic                    st_accept,
    output logic [21:0]             rd1_tag,
    output logic [6:0]              rd1_idx,
    input  logic [63:0]             rd1_data,
    input  logic                    rd1_valid,
    output logic                    wr1_en,
    output logic [21:0]             wr1_tag,
    output logic [6:0]              wr1_idx,
    output logic [63:0]             wr1_data,
    output logic                    wr2_en,
    output logic [21:0]             wr2_tag,
    output logic [6:0]              wr2_idx,
    output logic [63:0]             wr2_data,
    output logic [1:0]              proc2mem_command,
    output logic [31:0]             proc2mem_addr,
    output logic [63:0]             proc2mem_data,
    input  logic [MEM_TAG_W-1:0]    mem2proc_response,
    input  logic [63:0]             mem2proc_data,
    input  logic [MEM_TAG_W-1:0]    mem2proc_tag,
    output logic [31:0]             hit_count,
    output logic [31:0]             miss_count,
    output logic [2*MSHR_DEPTH-1:0] dbg_mshr_state
);

    typedef enum logic [1:0] {
        MSHR_INVALID = 2'd0,
        MSHR_ISSUE   = 2'd1,
        MSHR_WAIT    = 2'd2
    } mshr_state_e;

    localparam logic [1:0] CMD_NONE  = 2'd0;
    localparam logic [1:0] CMD_LOAD  = 2'd1;
    localparam logic [1:0] CMD_STORE = 2'd2;

    mshr_state_e          r_state    [MSHR_DEPTH];
    logic [28:0]          r_line     [MSHR_DEPTH];
    logic [MEM_TAG_W-1:0] r_mtag     [MSHR_DEPTH];
    mshr_state_e          w_state_nxt[MSHR_DEPTH];
    logic [28:0]          w_line_nxt [MSHR_DEPTH];
    logic [MEM_TAG_W-1:0] w_mtag_nxt [MSHR_DEPTH];

    logic [28:0]           w_ld_line;
    logic [28:0]           w_st_line;
    logic [MSHR_DEPTH-1:0] w_fill_oh;
    logic [MSHR_DEPTH-1:0] w_free_oh;
    logic [MSHR_DEPTH-1:0] w_issue_oh;
    logic                  w_fill_any;
    logic                  w_free_any;
    logic                  w_issue_any;
    logic [28:0]           w_fill_line;
    logic [28:0]           w_issue_line;
    logic                  w_ld_merge;
    logic                  w_st_conflict;
    logic                  w_fwd;
    logic                  w_ld_act;
    logic                  w_alloc;
    logic                  w_load_go;
    logic                  w_load_acc;
    logic                  w_st_go;
    logic                  w_fill_idx_clash;
    logic                  w_resp_ok;
    logic                  w_unused;

    assign w_ld_line = ld_addr[31:3];
    assign w_st_line = st_addr[31:3];
    assign w_unused  = ^{ld_addr[2:0], st_addr[2:0]};

    // One pass over the MSHR: fill match, line matches, lowest free and lowest ISSUE entry.
    always_comb begin
        w_fill_oh     = '0;
        w_free_oh     = '0;
        w_issue_oh    = '0;
        w_fill_any    = 1'b0;
        w_free_any    = 1'b0;
        w_issue_any   = 1'b0;
        w_fill_line   = '0;
        w_issue_line  = '0;
        w_ld_merge    = 1'b0;
        w_st_conflict = 1'b0;
        for (int i = 0; i < MSHR_DEPTH; i++) begin
            if (r_state[i] == MSHR_WAIT && mem2proc_tag != '0 && r_mtag[i] == mem2proc_tag) begin
                w_fill_oh[i] = 1'b1;
                w_fill_any   = 1'b1;
                w_fill_line  = r_line[i];
            end
            if (r_state[i] != MSHR_INVALID) begin
                if (r_line[i] == w_ld_line) w_ld_merge = 1'b1;
                if (r_line[i] == w_st_line) w_st_conflict = 1'b1;
            end
            if (r_state[i] == MSHR_INVALID && !w_free_any) begin
                w_free_oh[i] = 1'b1;
                w_free_any   = 1'b1;
            end
            if (r_state[i] == MSHR_ISSUE && !w_issue_any) begin
                w_issue_oh[i] = 1'b1;
                w_issue_any   = 1'b1;
                w_issue_line  = r_line[i];
            end
        end
    end

    // The array port serves the load when present, otherwise the store's hit check.
    assign rd1_tag = ld_en ? ld_addr[31:10] : st_addr[31:10];
    assign rd1_idx = ld_en ? ld_addr[9:3]   : st_addr[9:3];

    assign w_fwd     = w_fill_any && (w_fill_line == w_ld_line);
    assign w_ld_act  = ld_en && !reset;
    assign ld_hit    = w_ld_act && (rd1_valid || w_fwd);
    assign ld_data   = !ld_hit ? 64'd0 : (rd1_valid ? rd1_data : mem2proc_data);
    assign ld_stall  = w_ld_act && !ld_hit;
    assign w_alloc   = ld_stall && !w_ld_merge && w_free_any;
    assign w_resp_ok = (mem2proc_response != '0);

    assign w_fill_idx_clash = w_fill_any && (w_fill_line[6:0] == st_addr[9:3]);
    assign w_load_go  = !reset && w_issue_any;
    assign w_load_acc = w_load_go && w_resp_ok;
    assign w_st_go    = !reset && !w_issue_any && st_en && !ld_en
                        && !w_st_conflict && !w_fill_idx_clash;

    assign proc2mem_command = w_load_go ? CMD_LOAD : (w_st_go ? CMD_STORE : CMD_NONE);
    assign proc2mem_addr    = w_load_go ? {w_issue_line, 3'b000}
                            : (w_st_go ? {w_st_line, 3'b000} : 32'd0);
    assign proc2mem_data    = w_st_go ? st_data : 64'd0;
    assign st_accept        = w_st_go && w_resp_ok;

    assign wr1_en   = !reset && w_fill_any;
    assign wr1_tag  = wr1_en ? w_fill_line[28:7] : 22'd0;
    assign wr1_idx  = wr1_en ? w_fill_line[6:0]  : 7'd0;
    assign wr1_data = wr1_en ? mem2proc_data     : 64'd0;

    // Write-through, no-allocate: only a store that hits in the array updates it.
    assign wr2_en   = st_accept && rd1_valid;
    assign wr2_tag  = wr2_en ? st_addr[31:10] : 22'd0;
    assign wr2_idx  = wr2_en ? st_addr[9:3]   : 7'd0;
    assign wr2_data = wr2_en ? st_data        : 64'd0;

    // Per-entry transitions are mutually exclusive: fill needs WAIT, issue needs ISSUE, alloc needs INVALID.
    always_comb begin
        for (int i = 0; i < MSHR_DEPTH; i++) begin
            w_state_nxt[i] = r_state[i];
            w_line_nxt[i]  = r_line[i];
            w_mtag_nxt[i]  = r_mtag[i];
            if (w_fill_oh[i]) begin
                w_state_nxt[i] = MSHR_INVALID;
            end else if (w_issue_oh[i] && w_load_acc) begin
                w_state_nxt[i] = MSHR_WAIT;
                w_mtag_nxt[i]  = mem2proc_response;
            end else if (w_free_oh[i] && w_alloc) begin
                w_state_nxt[i] = MSHR_ISSUE;
                w_line_nxt[i]  = w_ld_line;
                w_mtag_nxt[i]  = '0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < MSHR_DEPTH; i++) begin
                r_state[i] <= MSHR_INVALID;
                r_line[i]  <= '0;
                r_mtag[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < MSHR_DEPTH; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_line[i]  <= w_line_nxt[i];
                r_mtag[i]  <= w_mtag_nxt[i];
            end
        end
    end

    always_comb begin
        dbg_mshr_state = '0;
        for (int i = 0; i < MSHR_DEPTH; i++) begin
            dbg_mshr_state[2*i +: 2] = r_state[i];
        end
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] r_hit_cnt;
    logic [31:0] r_miss_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_hit_cnt  <= 32'd0;
            r_miss_cnt <= 32'd0;
        end else begin
            if (ld_hit && r_hit_cnt != 32'hFFFF_FFFF) r_hit_cnt <= r_hit_cnt + 32'd1;
            if (w_alloc && r_miss_cnt != 32'hFFFF_FFFF) r_miss_cnt <= r_miss_cnt + 32'd1;
        end
    end

    assign hit_count  = r_hit_cnt;
    assign miss_count = r_miss_cnt;
`else
    assign hit_count  = 32'd0;
    assign miss_count = 32'd0;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Randomized bench for dcache_ctrl: bench-side array, memory and MSHR model predict every cycle's
// outputs into a queue; a monitor pops and compares them half a cycle later.
`timescale 1ns/1ps
module tb_dcache_ctrl;
    localparam int MSHR_DEPTH = 4;
    localparam int MEM_TAG_W  = 4;
    localparam int N_CYCLES   = 4000;

    logic        clock = 1'b0;
    logic        reset;
    logic        ld_en;
    logic [31:0] ld_addr;
    logic        ld_hit;
    logic [63:0] ld_data;
    logic        ld_stall;
    logic        st_en;
    logic [31:0] st_addr;
    logic [63:0] st_data;
    logic        st_accept;
    logic [21:0] rd1_tag;
    logic [6:0]  rd1_idx;
    logic [63:0] rd1_data;
    logic        rd1_valid;
    logic        wr1_en, wr2_en;
    logic [21:0] wr1_tag, wr2_tag;
    logic [6:0]  wr1_idx, wr2_idx;
    logic [63:0] wr1_data, wr2_data;
    logic [1:0]  proc2mem_command;
    logic [31:0] proc2mem_addr;
    logic [63:0] proc2mem_data;
    logic [MEM_TAG_W-1:0] mem2proc_response;
    logic [63:0]          mem2proc_data;
    logic [MEM_TAG_W-1:0] mem2proc_tag;
    logic [31:0] hit_count, miss_count;
    logic [2*MSHR_DEPTH-1:0] dbg_mshr_state;

    always #5 clock = ~clock;

    dcache_ctrl #(.MSHR_DEPTH(MSHR_DEPTH), .MEM_TAG_W(MEM_TAG_W)) dut (
        .clock(clock), .reset(reset),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_hit(ld_hit), .ld_data(ld_data), .ld_stall(ld_stall),
        .st_en(st_en), .st_addr(st_addr), .st_data(st_data), .st_accept(st_accept),
        .rd1_tag(rd1_tag), .rd1_idx(rd1_idx), .rd1_data(rd1_data), .rd1_valid(rd1_valid),
        .wr1_en(wr1_en), .wr1_tag(wr1_tag), .wr1_idx(wr1_idx), .wr1_data(wr1_data),
        .wr2_en(wr2_en), .wr2_tag(wr2_tag), .wr2_idx(wr2_idx), .wr2_data(wr2_data),
        .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
        .proc2mem_data(proc2mem_data), .mem2proc_response(mem2proc_response),
        .mem2proc_data(mem2proc_data), .mem2proc_tag(mem2proc_tag),
        .hit_count(hit_count), .miss_count(miss_count), .dbg_mshr_state(dbg_mshr_state)
    );

    typedef struct packed {
        logic        chk;
        logic [21:0] rd1_tag;
        logic [6:0]  rd1_idx;
        logic        ld_hit;
        logic [63:0] ld_data;
        logic        ld_stall;
        logic [1:0]  cmd;
        logic [31:0] addr;
        logic [63:0] pdata;
        logic        st_accept;
        logic        wr1_en;
        logic [21:0] wr1_tag;
        logic [6:0]  wr1_idx;
        logic [63:0] wr1_data;
        logic        wr2_en;
        logic [21:0] wr2_tag;
        logic [6:0]  wr2_idx;
        logic [63:0] wr2_data;
        logic [31:0] hits;
        logic [31:0] misses;
    } exp_t;
    localparam int EXP_W = $bits(exp_t);
    logic [EXP_W-1:0] exp_q[$];

    // Reference state: outstanding misses, the cache array contents, backing memory, bus tags.
    typedef struct { bit v; bit sent; logic [28:0] line; logic [3:0] mtag; } miss_t;
    typedef struct { logic [3:0] tag; logic [28:0] line; } busy_t;
    miss_t       mshr[MSHR_DEPTH];
    bit          c_valid[128];
    logic [21:0] c_tag[128];
    logic [63:0] c_data[128];
    logic [63:0] mem[logic [28:0]];
    busy_t       outq[$];
    longint unsigned m_hits, m_misses;
    bit hold_ld, hold_st;
    int ld_pct, st_pct, ret_pct;
    int n_tests = 0;
    int n_fail  = 0;

    function automatic logic [31:0] pick_addr();
        logic [21:0] t;
        int sel;
        sel = $urandom_range(0, 2);
        t = (sel == 0) ? 22'h0 : ((sel == 1) ? 22'h12345 : 22'h3FFFFF);
        return {t, 7'($urandom_range(1, 4)), 3'($urandom_range(0, 7))};
    endfunction

    function automatic logic [63:0] mem_rd(input logic [28:0] l);
        if (mem.exists(l)) return mem[l];
        return {3'b101, l, 3'b011, ~l};
    endfunction

    function automatic bit tag_busy(input logic [3:0] t);
        foreach (outq[k]) if (outq[k].tag == t) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [3:0] pick_free_tag(input logic [3:0] avoid);
        logic [3:0] t;
        for (int tries = 0; tries < 16; tries++) begin
            t = 4'($urandom_range(1, 15));
            if (t != avoid && !tag_busy(t)) return t;
        end
        return 4'd0;
    endfunction

    task automatic drive_cycle(input bit rst);
        exp_t e;
        logic [31:0] a_rd;
        logic [28:0] ld_line, st_line;
        int fi, free_i, iss_i, k;
        bit fwd, merge, st_blk, st_go;
        @(negedge clock);
        reset = rst;
        if (!(hold_ld && $urandom_range(0, 9) < 8)) begin
            ld_en   = ($urandom_range(0, 99) < ld_pct);
            ld_addr = pick_addr();
        end
        if (!(hold_st && $urandom_range(0, 9) < 8)) begin
            st_en   = ($urandom_range(0, 99) < st_pct);
            st_addr = pick_addr();
            st_data = {$urandom, $urandom};
        end
        mem2proc_tag  = '0;
        mem2proc_data = {$urandom, $urandom};
        if (outq.size() > 0 && $urandom_range(0, 99) < ret_pct) begin
            k = $urandom_range(0, outq.size() - 1);
            mem2proc_tag  = outq[k].tag;
            mem2proc_data = mem_rd(outq[k].line);
            outq.delete(k);
        end else if ($urandom_range(0, 99) < 4) begin
            mem2proc_tag = pick_free_tag(4'd0);
        end
        mem2proc_response = ($urandom_range(0, 99) < 35) ? 4'd0 : pick_free_tag(mem2proc_tag);
        a_rd      = ld_en ? ld_addr : st_addr;
        rd1_valid = c_valid[a_rd[9:3]] && (c_tag[a_rd[9:3]] == a_rd[31:10]);
        rd1_data  = rd1_valid ? c_data[a_rd[9:3]] : {$urandom, $urandom};

        e = '0;
        e.rd1_tag = a_rd[31:10];
        e.rd1_idx = a_rd[9:3];
        if (rst) begin
            foreach (mshr[i]) mshr[i].v = 1'b0;
            m_hits = 0;
            m_misses = 0;
            hold_ld = 1'b0;
            hold_st = 1'b0;
            exp_q.push_back(e);
            return;
        end
        e.chk   = 1'b1;
        ld_line = ld_addr[31:3];
        st_line = st_addr[31:3];
        fi = -1; free_i = -1; iss_i = -1; merge = 1'b0; st_blk = 1'b0;
        foreach (mshr[i]) begin
            if (mshr[i].v && mshr[i].sent && mem2proc_tag != 0 && mshr[i].mtag == mem2proc_tag) fi = i;
            if (mshr[i].v && mshr[i].line == ld_line) merge = 1'b1;
            if (mshr[i].v && mshr[i].line == st_line) st_blk = 1'b1;
            if (!mshr[i].v && free_i < 0) free_i = i;
            if (mshr[i].v && !mshr[i].sent && iss_i < 0) iss_i = i;
        end
        fwd = (fi >= 0) && (mshr[fi].line == ld_line);
        e.ld_hit   = ld_en && (rd1_valid || fwd);
        e.ld_data  = rd1_valid ? rd1_data : mem2proc_data;
        e.ld_stall = ld_en && !e.ld_hit;
        if (fi >= 0 && mshr[fi].line[6:0] == st_addr[9:3]) st_blk = 1'b1;
        st_go = (iss_i < 0) && st_en && !ld_en && !st_blk;
        if (iss_i >= 0) begin
            e.cmd  = 2'd1;
            e.addr = {mshr[iss_i].line, 3'b000};
        end else if (st_go) begin
            e.cmd   = 2'd2;
            e.addr  = {st_line, 3'b000};
            e.pdata = st_data;
        end
        e.st_accept = st_go && (mem2proc_response != 0);
        e.wr2_en    = e.st_accept && rd1_valid;
        e.wr2_tag   = st_addr[31:10];
        e.wr2_idx   = st_addr[9:3];
        e.wr2_data  = st_data;
        if (fi >= 0) begin
            e.wr1_en   = 1'b1;
            e.wr1_tag  = mshr[fi].line[28:7];
            e.wr1_idx  = mshr[fi].line[6:0];
            e.wr1_data = mem2proc_data;
        end
`ifdef DCACHE_STATS_EN
        e.hits   = (m_hits   > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : m_hits[31:0];
        e.misses = (m_misses > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : m_misses[31:0];
`endif
        exp_q.push_back(e);

        if (fi >= 0) begin
            c_valid[e.wr1_idx] = 1'b1;
            c_tag[e.wr1_idx]   = e.wr1_tag;
            c_data[e.wr1_idx]  = mem2proc_data;
            mshr[fi].v = 1'b0;
        end
        if (iss_i >= 0 && mem2proc_response != 0) begin
            mshr[iss_i].sent = 1'b1;
            mshr[iss_i].mtag = mem2proc_response;
            outq.push_back('{mem2proc_response, mshr[iss_i].line});
        end
        if (e.ld_stall && !merge && free_i >= 0) begin
            mshr[free_i] = '{1'b1, 1'b0, ld_line, 4'd0};
            m_misses++;
        end
        if (e.st_accept) mem[st_line] = st_data;
        if (e.wr2_en) c_data[st_addr[9:3]] = st_data;
        if (e.ld_hit) m_hits++;
        hold_ld = e.ld_stall;
        hold_st = st_en && !e.st_accept;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares one predicted output record per cycle, mid-way between clock edges.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_t'(exp_q.pop_front());
                if (e.chk) begin
                    check("rd1_addr", {rd1_tag, rd1_idx}, {e.rd1_tag, e.rd1_idx});
                    check("ld_hit", ld_hit, e.ld_hit);
                    check("ld_stall", ld_stall, e.ld_stall);
                    if (e.ld_hit) check("ld_data", ld_data, e.ld_data);
                    check("command", proc2mem_command, e.cmd);
                    if (e.cmd != 2'd0) check("mem_addr", proc2mem_addr, e.addr);
                    if (e.cmd == 2'd2) check("mem_data", proc2mem_data, e.pdata);
                    check("st_accept", st_accept, e.st_accept);
                    check("wr1_en", wr1_en, e.wr1_en);
                    if (e.wr1_en) check("wr1_line", {wr1_tag, wr1_idx}, {e.wr1_tag, e.wr1_idx});
                    if (e.wr1_en) check("wr1_data", wr1_data, e.wr1_data);
                    check("wr2_en", wr2_en, e.wr2_en);
                    if (e.wr2_en) check("wr2_line", {wr2_tag, wr2_idx}, {e.wr2_tag, e.wr2_idx});
                    if (e.wr2_en) check("wr2_data", wr2_data, e.wr2_data);
                    check("hit_count", hit_count, e.hits);
                    check("miss_count", miss_count, e.misses);
                end
            end
        end
    end

    initial begin
        reset = 1'b1; ld_en = 1'b0; ld_addr = '0; st_en = 1'b0; st_addr = '0; st_data = '0;
        rd1_data = '0; rd1_valid = 1'b0; mem2proc_response = '0; mem2proc_data = '0; mem2proc_tag = '0;
        foreach (c_valid[i]) begin
            c_valid[i] = 1'b0;
            c_tag[i]   = '0;
            c_data[i]  = '0;
        end
        foreach (mshr[i]) mshr[i] = '{1'b0, 1'b0, 29'd0, 4'd0};
        hold_ld = 1'b0; hold_st = 1'b0; m_hits = 0; m_misses = 0;
        ld_pct = 60; st_pct = 40; ret_pct = 30;
        repeat (3) drive_cycle(1'b1);
        for (int c = 0; c < N_CYCLES; c++) begin
            if (c < 1200) begin
                ld_pct = 60; st_pct = 40; ret_pct = 30;
            end else if (c < 2400) begin
                ld_pct = 95; st_pct = 20; ret_pct = 8;
            end else begin
                ld_pct = 30; st_pct = 80; ret_pct = 40;
            end
            drive_cycle(c >= 2500 && c < 2502);
        end
        ld_pct = 0; st_pct = 0;
        hold_ld = 1'b0; hold_st = 1'b0;
        repeat (2) drive_cycle(1'b0);
        for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge clock);
        #4;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d records left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
